// File: rtl/seq_compare_ctrl.sv
// Sequential magnitude comparator: one 4-bit slice per clock, cascade state held in registers.
// Optional MSB-first early-exit scan enabled by defining SEQ_COMPARE_EARLY_EXIT_EN.
module seq_compare_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             IAGB,
  input  logic             IALB,
  input  logic             IAEB,
  output logic             busy,
  output logic             done,
  output logic             FAGB,
  output logic             FALB,
  output logic             FAEB
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       gle_q;
  logic [IDXW-1:0]  idx_q;
  logic             busy_q;
  logic             done_q;
  logic [2:0]       f_q;

  logic [3:0]       a_sl_s;
  logic [3:0]       b_sl_s;
  logic [2:0]       gle_d;
  logic             finish_s;

  // Mux one 4-bit slice out of a wide operand.
  function automatic logic [3:0] slice_f(input logic [WIDTH-1:0] v, input logic [IDXW-1:0] idx);
    logic [3:0] r;
    r = 4'h0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IDXW'(n)) begin
        r = v[4*n +: 4];
      end
    end
    return r;
  endfunction

  // Map the raw cascade inputs to the {G,L,E} state the scan starts from.
  function automatic logic [2:0] seed_f(input logic gt, input logic lt, input logic eq);
    logic [2:0] r;
    if (eq) begin
      r = 3'b001;
    end else begin
      case ({gt, lt})
        2'b10:   r = 3'b100;
        2'b01:   r = 3'b010;
        2'b11:   r = 3'b000;
        2'b00:   r = 3'b110;
        default: r = 3'b000;
      endcase
    end
    return r;
  endfunction

  assign a_sl_s = slice_f(a_q, idx_q);
  assign b_sl_s = slice_f(b_q, idx_q);

  // An unequal slice overwrites the cascade state; an equal slice keeps it.
  always_comb begin
    gle_d = gle_q;
    if (a_sl_s > b_sl_s) begin
      gle_d = 3'b100;
    end else if (a_sl_s < b_sl_s) begin
      gle_d = 3'b010;
    end else begin
      gle_d = gle_q;
    end
  end

`ifdef SEQ_COMPARE_EARLY_EXIT_EN
  localparam logic [IDXW-1:0] FIRST_IDX = LAST_IDX;
  logic slice_ne_s;
  assign slice_ne_s = (a_sl_s != b_sl_s);
  // Scanning from the top, the first differing slice decides the result.
  assign finish_s   = slice_ne_s || (idx_q == {IDXW{1'b0}});
`else
  localparam logic [IDXW-1:0] FIRST_IDX = {IDXW{1'b0}};
  assign finish_s   = (idx_q == LAST_IDX);
`endif

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      gle_q   <= 3'b000;
      idx_q   <= {IDXW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      f_q     <= 3'b000;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            gle_q   <= seed_f(IAGB, IALB, IAEB);
            idx_q   <= FIRST_IDX;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          gle_q <= gle_d;
          if (finish_s) begin
            f_q     <= gle_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
            idx_q   <= idx_q - {{(IDXW-1){1'b0}}, 1'b1};
`else
            idx_q   <= idx_q + {{(IDXW-1){1'b0}}, 1'b1};
`endif
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign FAGB = f_q[2];
  assign FALB = f_q[1];
  assign FAEB = f_q[0];

endmodule

// File: tb/tb_seq_compare_ctrl.sv
// Directed self-checking bench for seq_compare_ctrl (WIDTH=16), both scan orders.
module tb_seq_compare_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        IAGB;
  logic        IALB;
  logic        IAEB;
  logic        busy;
  logic        done;
  logic        FAGB;
  logic        FALB;
  logic        FAEB;

  int errors = 0;
  int checks = 0;

`ifdef SEQ_COMPARE_EARLY_EXIT_EN
  localparam int LAT_TOP = 1;
`else
  localparam int LAT_TOP = 4;
`endif

  seq_compare_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .IAGB  (IAGB),
    .IALB  (IALB),
    .IAEB  (IAEB),
    .busy  (busy),
    .done  (done),
    .FAGB  (FAGB),
    .FALB  (FALB),
    .FAEB  (FAEB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full comparison; checks busy after acceptance, latency, result and idle afterwards.
  task automatic do_cmp(input logic [15:0] a, input logic [15:0] b, input logic [2:0] seed,
                        input logic [2:0] exp_f, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    A = a; B = b; {IAGB, IALB, IAEB} = seed; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " F"}, {29'd0, FAGB, FALB, FAEB}, {29'd0, exp_f});
    check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int gap;
    logic seen_done;
    rst_n = 1'b0; start = 1'b1; A = 16'hFFFF; B = 16'h0000;
    IAGB = 1'b1; IALB = 1'b0; IAEB = 1'b0;

    // Reset held with start asserted
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst F", {29'd0, FAGB, FALB, FAEB}, 32'd0);
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post-rst idle", {31'd0, busy}, 32'd0);

    // Basic compares
    do_cmp(16'h1234, 16'h1233, 3'b001, 3'b100, 4, "gt_lsb");
    do_cmp(16'h0FFF, 16'h1000, 3'b001, 3'b010, LAT_TOP, "lt_msb");
    do_cmp(16'h8000, 16'h7FFF, 3'b001, 3'b100, LAT_TOP, "gt_top");
    do_cmp(16'hFFFF, 16'hFFFF, 3'b001, 3'b001, 4, "eq_ones");

    // Cascade seeds on equal operands
    do_cmp(16'hA5A5, 16'hA5A5, 3'b001, 3'b001, 4, "seed001");
    do_cmp(16'hA5A5, 16'hA5A5, 3'b100, 3'b100, 4, "seed100");
    do_cmp(16'hA5A5, 16'hA5A5, 3'b010, 3'b010, 4, "seed010");
    do_cmp(16'hA5A5, 16'hA5A5, 3'b110, 3'b000, 4, "seed110");
    do_cmp(16'hA5A5, 16'hA5A5, 3'b000, 3'b110, 4, "seed000");
    // An unequal slice overrides a non-one-hot seed
    do_cmp(16'h0000, 16'h0001, 3'b000, 3'b010, 4, "seed_ovr");

    // Protocol: start held during busy is ignored, start in done cycle is accepted
    @(negedge clk);
    A = 16'h1234; B = 16'h1233; {IAGB, IALB, IAEB} = 3'b001; start = 1'b1;
    @(posedge clk); #1;
    A = 16'h0000; B = 16'hFFFF;
    repeat (3) begin
      @(posedge clk); #1;
      check("proto busy", {30'd0, busy, done}, 32'd2);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("proto done1", {31'd0, done}, 32'd1);
    check("proto F1", {29'd0, FAGB, FALB, FAEB}, 32'd4);
    A = 16'h0001; B = 16'h0002; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("proto pulse", {30'd0, busy, done}, 32'd2);
    gap = 1;
    while (!done && gap < 20) begin
      @(posedge clk); #1;
      gap++;
    end
    check("proto gap", gap, 32'd5);
    check("proto F2", {29'd0, FAGB, FALB, FAEB}, 32'd2);

    // Abort by reset in the middle of a run
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0000; {IAGB, IALB, IAEB} = 3'b001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort F", {29'd0, FAGB, FALB, FAEB}, 32'd0);
    seen_done = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("abort no done", {31'd0, seen_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_cmp(16'h4321, 16'h4320, 3'b010, 3'b100, 4, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_compare_ctrl.md
Name: seq_compare_ctrl

Overview:
- Multi-cycle magnitude comparator for operands wider than 4 bits.
- Compares WIDTH-bit A and B one 4-bit slice per clock, LSB slice first.
- Holds the running cascade state (GT/LT/EQ) in registers and seeds it from external cascade inputs, so a narrower upstream stage can feed it.
- Used where a wide comparison must share one 4-bit slice comparator across cycles instead of a combinational cascade chain.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4, minimum 8.
- NIBBLES, WIDTH/4, derived slice count; not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while busy=0.
- A  input  WIDTH  operand A; captured when start is accepted.
- B  input  WIDTH  operand B; captured when start is accepted.
- IAGB  input  1  cascade seed "lower A > lower B"; captured with start.
- IALB  input  1  cascade seed "lower A < lower B"; captured with start.
- IAEB  input  1  cascade seed "lower A = lower B"; captured with start.
- busy  output  1  comparison in progress.
- done  output  1  one-cycle pulse; F* outputs are valid in this cycle.
- FAGB  output  1  result A > B.
- FALB  output  1  result A < B.
- FAEB  output  1  result A = B.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, FAGB=0, FALB=0, FAEB=0; operand and cascade registers cleared.
- Reset asserted mid-operation aborts the comparison. No done pulse is generated, and the outputs take their reset values.
- FSM has two states: IDLE and RUN.
  - IDLE: if start=1 at edge E0, capture A, B and the normalized seed; clear slice index to 0; busy=1; go to RUN. Otherwise hold.
  - RUN: at each edge Ei (i=1..NIBBLES), compare slice i-1 (bits 4(i-1)+3 : 4(i-1)).
  - A slice > B slice sets state {G,L,E}=100.
  - A slice < B slice sets state 010.
  - Equal slices leave the state unchanged.
  - At edge E_NIBBLES, load FAGB/FALB/FAEB from the final state, pulse done=1 for one cycle, set busy=0 and return to IDLE.
- Latency: start edge to done edge is NIBBLES clocks (4 for WIDTH=16). A new start may be sampled in the done cycle, giving back-to-back throughput of one comparison per NIBBLES+1 clocks.
- start while busy=1 is ignored; it is not queued.
- Seed normalization at capture, checked in priority order:
  - IAEB=1 gives 001.
  - IAGB=1, IALB=0 gives 100.
  - IAGB=0, IALB=1 gives 010.
  - IAGB=1, IALB=1 gives 000.
  - IAGB=0, IALB=0 gives 110.
- Non-one-hot seeds (000, 110) propagate to the outputs only if every slice is equal. Any unequal slice overwrites the state with one-hot 100 or 010.
- F* outputs hold the last result until the next done. They are not cleared by start.
- Operands are unsigned; no sign handling.

Optional Feature:
- Macro: SEQ_COMPARE_EARLY_EXIT_EN.
- Defined:
  - Slices are scanned MSB-first.
  - The first unequal slice at edge Ej sets the result and finishes: done is pulsed at Ej, so latency is j.
  - If all slices are equal, the normalized seed becomes the result at E_NIBBLES.
  - Final F* values are identical to the undefined build for all inputs.
- Undefined: fixed LSB-first scan with constant NIBBLES latency, as above.

Test Plan:
- Reset: hold rst_n=0 with start=1, then release -> busy=0, done=0, F*=000; no operation starts until start is sampled after release.
- Basic compare, WIDTH=16: A=16'h1234, B=16'h1233, seed IAEB=1, start for 1 cycle -> busy for 4 clocks; done at edge 4 with F*=100. Repeat with A=16'h0FFF, B=16'h1000 -> 010.
- Cascade seed: A=B=16'hA5A5 with each seed IAGB/IALB/IAEB = 001 (IAEB only), 100, 010, 110, 000 -> F* = 001, 100, 010, 000, 110 respectively.
- Protocol: pulse start again at cycles 1-3 during busy -> ignored; pulse start in the done cycle -> accepted, second done exactly 5 clocks after the first.
- Abort: drop rst_n at cycle 2 of a run -> F*=000 and no done pulse; a fresh start after release runs normally.
- SEQ_COMPARE_EARLY_EXIT_EN: A=16'h8000, B=16'h7FFF -> done at edge 1 with F*=100; A=B -> done at edge 4 with the seed result.
